pll_drp_reconfig: RTL and testbench
===================================

// Module: pll_drp_reconfig
// PURPOSE
// Upstream DRP master for the PLLE2_ADV_VPR cell: takes a stream of (address, mask, data) entries and applies each as a
// read-modify-write on the PLL dynamic reconfiguration port. Holds the PLL in reset for the whole sequence, then
// releases it and waits for LOCKED. Sits between the fabric reconfiguration controller and the PLL DCLK/DEN/DWE/DADDR/DI/DO/DRDY pins.
// PARAMETERS
// RST_HOLD       4     cycles PLL_RST is held before the first DRP access (>=1)
// DRDY_TIMEOUT   64    max cycles from DEN to DRDY before the ERROR abort (>=2)
// LOCK_TIMEOUT   4096  max cycles from PLL_RST release to LOCKED before the ERROR abort (>=2)
// PORTS
// DCLK       in   1   clock; the same clock drives the PLL DCLK pin
// RST_N      in   1   asynchronous, active-low reset
// CFG_VALID  in   1   entry valid
// CFG_READY  out  1   entry accepted when CFG_VALID & CFG_READY
// CFG_ADDR   in   7   DRP register address
// CFG_MASK   in   16  1 = keep existing bit, 0 = replace with CFG_DATA bit
// CFG_DATA   in   16  new bit values
// CFG_LAST   in   1   marks the final entry of a sequence
// DEN        out  1   DRP enable, to PLL
// DWE        out  1   DRP write enable, to PLL
// DADDR      out  7   DRP address, to PLL
// DI         out  16  DRP write data, to PLL
// DO         in   16  DRP read data, from PLL
// DRDY       in   1   DRP access complete, from PLL
// PLL_RST    out  1   to PLL RST pin (active-high)
// LOCKED     in   1   from PLL
// BUSY       out  1   high in every state except IDLE
// DONE       out  1   1-cycle pulse when a sequence completes with LOCKED
// ERROR      out  1   sticky; cleared when the next sequence starts
// BEHAVIOUR
// - Reset values: DEN=DWE=0, DADDR=0, DI=0, PLL_RST=0, CFG_READY=0, BUSY=0, DONE=0, ERROR=0. FSM goes to IDLE.
// - Reset asserted mid-sequence aborts immediately; no partial write completes, and PLL_RST drops.
// - IDLE: CFG_VALID=1 -> HOLD. Entry is not consumed. ERROR clears and PLL_RST is set to 1.
// - HOLD: counts RST_HOLD cycles -> WAIT_CFG.
// - WAIT_CFG: CFG_READY=1. On handshake, latch ADDR/MASK/DATA/LAST and go to READ.
// - READ: single-cycle DEN=1, DWE=0, DADDR=addr -> WAIT_RD.
// - WAIT_RD: on DRDY, capture DO -> WRITE.
// - WRITE: single-cycle DEN=1, DWE=1, DI=(DO_cap & MASK) | (DATA & ~MASK) -> WAIT_WR.
// - WAIT_WR: on DRDY, if LAST -> RELEASE, else -> WAIT_CFG.
// - RELEASE: PLL_RST=0 -> WAIT_LOCK.
// - WAIT_LOCK: LOCKED=1 -> DONE pulse -> IDLE.
// - DEN is never high for two consecutive cycles. DADDR and DI stay stable from DEN through DRDY.
// - Earliest DRDY is the cycle after DEN. DRDY coincident with DEN, and DRDY in any non-WAIT state, are ignored.
// - Timeouts: a wait counter resets on entry to WAIT_RD, WAIT_WR and WAIT_LOCK.
// - DRP timeout: DRDY_TIMEOUT cycles without DRDY -> ERROR=1, PLL_RST=0, go to IDLE. Entries still pending upstream are not drained.
// - Lock timeout: LOCK_TIMEOUT cycles without LOCKED -> ERROR=1, go to IDLE. No DONE pulse.
// - DRDY and timeout expiry in the same cycle: DRDY wins.
// - Best case, per entry: handshake to write-DRDY in 4 cycles when DRDY arrives the cycle after DEN.
// - Counters saturate; they never wrap.
// TESTING
// - Single entry (ADDR=0x08, MASK=0xF000, DATA=0x0ABC), PLL model returns DO=0x5123 -> one read, then write DI=0x5ABC; PLL_RST high throughout; DONE pulses once after LOCKED.
// - 3-entry burst with CFG_LAST on the 3rd and CFG_VALID gaps of 2 cycles -> exactly 3 reads and 3 writes in order; CFG_READY low outside WAIT_CFG.
// - DRDY never returned on the 2nd read, DRDY_TIMEOUT=64 -> ERROR=1 64 cycles after DEN, PLL_RST=0, BUSY=0, no DONE.
// - LOCKED held low, LOCK_TIMEOUT=4096 -> ERROR at cycle 4096 after release; next CFG_VALID clears ERROR.
// - RST_N pulled low during WAIT_WR -> all outputs at reset values asynchronously; a new sequence after release runs cleanly.
// - Spurious DRDY in IDLE and in HOLD -> no state change; DEN never asserted on consecutive cycles (assertion).

Source files
------------

// File: rtl/pll_drp_reconfig_if.sv
// Signal bundle between the reconfiguration controller, the DRP master and the PLL pins.
// The master modport is the DRP master's view; the slave modport is the environment's view.
interface pll_drp_reconfig_if;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [6:0]  CFG_ADDR;
    logic [15:0] CFG_MASK;
    logic [15:0] CFG_DATA;
    logic        CFG_LAST;
    logic        DEN;
    logic        DWE;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;
    logic        PLL_RST;
    logic        LOCKED;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    modport master (
        input  CFG_VALID, CFG_ADDR, CFG_MASK, CFG_DATA, CFG_LAST, DO, DRDY, LOCKED,
        output CFG_READY, DEN, DWE, DADDR, DI, PLL_RST, BUSY, DONE, ERROR
    );

    modport slave (
        output CFG_VALID, CFG_ADDR, CFG_MASK, CFG_DATA, CFG_LAST, DO, DRDY, LOCKED,
        input  CFG_READY, DEN, DWE, DADDR, DI, PLL_RST, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/pll_drp_reconfig.sv
// DRP master for the PLL: applies a stream of (addr, mask, data) entries as read-modify-writes
// while holding the PLL in reset, then releases it and waits for LOCKED.
module pll_drp_reconfig #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic               DCLK,
    input  logic               RST_N,
    pll_drp_reconfig_if.master bus
);
    localparam int MAX_WAIT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int MAX_CNT  = (RST_HOLD > MAX_WAIT) ? RST_HOLD : MAX_WAIT;
    localparam int CW       = $clog2(MAX_CNT + 1);

    // The wait counter starts at zero the cycle after DEN (or after PLL_RST release), so
    // matching against TIMEOUT-2 puts ERROR on the output exactly TIMEOUT cycles later.
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRP_LAST  = CW'(DRDY_TIMEOUT - 2);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 2);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOLD      = 4'd1,
        ST_WAIT_CFG  = 4'd2,
        ST_READ      = 4'd3,
        ST_WAIT_RD   = 4'd4,
        ST_WRITE     = 4'd5,
        ST_WAIT_WR   = 4'd6,
        ST_RELEASE   = 4'd7,
        ST_WAIT_LOCK = 4'd8
    } state_e;

    function automatic logic [15:0] rmw_merge(input logic [15:0] old_val,
                                              input logic [15:0] keep_mask,
                                              input logic [15:0] new_val);
        return (old_val & keep_mask) | (new_val & ~keep_mask);
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   mask_q, mask_d;
    logic [15:0]   data_q, data_d;
    logic          last_q, last_d;
    logic [15:0]   di_q, di_d;
    logic          den_q, den_d;
    logic          dwe_q, dwe_d;
    logic          pll_rst_q, pll_rst_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cfg_fire_s;
    logic          timeout_s;

    assign cfg_fire_s = (state_q == ST_WAIT_CFG) && cfg_ready_q && bus.CFG_VALID;

    // State register.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a DRDY or LOCKED arriving on the expiry cycle takes priority.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CFG_VALID) state_d = ST_HOLD;
                else               state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (cnt_q >= HOLD_LAST) state_d = ST_WAIT_CFG;
                else                    state_d = ST_HOLD;
            end
            ST_WAIT_CFG: begin
                if (cfg_fire_s) state_d = ST_READ;
                else            state_d = ST_WAIT_CFG;
            end
            ST_READ: state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (bus.DRDY) begin
                    state_d = ST_WRITE;
                end else if (cnt_q >= DRP_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WRITE: state_d = ST_WAIT_WR;
            ST_WAIT_WR: begin
                if (bus.DRDY) begin
                    if (last_q) state_d = ST_RELEASE;
                    else        state_d = ST_WAIT_CFG;
                end else if (cnt_q >= DRP_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_WR;
                end
            end
            ST_RELEASE: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (bus.LOCKED) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= LOCK_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are decoded from the upcoming state so they are registered.
    always_comb begin
        addr_d = addr_q;
        mask_d = mask_q;
        data_d = data_q;
        last_d = last_q;
        if (cfg_fire_s) begin
            addr_d = bus.CFG_ADDR;
            mask_d = bus.CFG_MASK;
            data_d = bus.CFG_DATA;
            last_d = bus.CFG_LAST;
        end else begin
            last_d = last_q;
        end

        if ((state_q == ST_WAIT_RD) && bus.DRDY) di_d = rmw_merge(bus.DO, mask_q, data_q);
        else                                     di_d = di_q;

        if (state_d != state_q)   cnt_d = {CW{1'b0}};
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        else                       cnt_d = cnt_q;

        den_d       = (state_d == ST_READ) || (state_d == ST_WRITE);
        dwe_d       = (state_d == ST_WRITE);
        pll_rst_d   = state_d inside {ST_HOLD, ST_WAIT_CFG, ST_READ, ST_WAIT_RD, ST_WRITE, ST_WAIT_WR};
        cfg_ready_d = (state_d == ST_WAIT_CFG);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_q == ST_WAIT_LOCK) && bus.LOCKED;

        if ((state_q == ST_IDLE) && bus.CFG_VALID) error_d = 1'b0;
        else if (timeout_s)                        error_d = 1'b1;
        else                                       error_d = error_q;
    end

    // Datapath and output registers.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q       <= {CW{1'b0}};
            addr_q      <= 7'd0;
            mask_q      <= 16'd0;
            data_q      <= 16'd0;
            last_q      <= 1'b0;
            di_q        <= 16'd0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            pll_rst_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            di_q        <= di_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            pll_rst_q   <= pll_rst_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.CFG_READY = cfg_ready_q;
    assign bus.DEN       = den_q;
    assign bus.DWE       = dwe_q;
    assign bus.DADDR     = addr_q;
    assign bus.DI        = di_q;
    assign bus.PLL_RST   = pll_rst_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERROR     = error_q;
endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: a behavioural PLL register file answers DRP accesses while a
// reference memory, updated with the mask/data rule, predicts every read and write.
module tb_pll_drp_reconfig;
    localparam int RST_HOLD     = 4;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 4096;

    logic DCLK;
    logic RST_N;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    pll_drp_reconfig_if bus();

    pll_drp_reconfig #(
        .RST_HOLD    (RST_HOLD),
        .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .DCLK (DCLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    logic [15:0] pll_mem [0:127];
    logic [15:0] exp_mem [0:127];
    logic [6:0]  exp_a [$];
    logic [15:0] exp_di [$];
    logic        log_we [$];
    logic [6:0]  log_a [$];
    logic [15:0] log_di [$];
    int          log_cyc [$];

    int          pend;
    logic        pend_we;
    logic [6:0]  pend_a;
    logic [15:0] pend_di;
    logic        den_prev;
    int          rd_idx;
    int          done_cnt;
    int          fixed_dly  = 1;
    bit          rand_dly   = 1'b0;
    int          drop_rd    = -1;
    int          spur_until = 0;

    initial begin
        DCLK = 1'b0;
        forever #5 DCLK = ~DCLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge DCLK);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        assert (obs === exp_v) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // PLL DRP responder: answers each DEN after a delay, commits writes only when DRDY is returned.
    initial begin
        bus.DRDY = 1'b0;
        bus.DO   = 16'h0000;
        pend     = 0;
        den_prev = 1'b0;
        rd_idx   = 0;
        done_cnt = 0;
        forever begin
            @(negedge DCLK);
            bus.DRDY = (cyc < spur_until);
            if (!RST_N) begin
                pend = 0;
            end else if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    bus.DRDY = 1'b1;
                    chk("daddr_stable", 32'(bus.DADDR), 32'(pend_a));
                    if (pend_we) begin
                        chk("di_stable", 32'(bus.DI), 32'(pend_di));
                        pll_mem[pend_a] = pend_di;
                    end else begin
                        bus.DO = pll_mem[pend_a];
                    end
                end
            end
            if (bus.DEN === 1'b1) begin
                chk("den_back_to_back", 32'(den_prev), 32'd0);
                chk("pll_rst_during_drp", 32'(bus.PLL_RST), 32'd1);
                chk("cfg_ready_during_drp", 32'(bus.CFG_READY), 32'd0);
                log_we.push_back(bus.DWE);
                log_a.push_back(bus.DADDR);
                log_di.push_back(bus.DI);
                log_cyc.push_back(cyc);
                if (!bus.DWE) rd_idx = rd_idx + 1;
                if (bus.DWE || (rd_idx != drop_rd)) begin
                    pend    = rand_dly ? int'($urandom_range(1, 4)) : fixed_dly;
                    pend_we = bus.DWE;
                    pend_a  = bus.DADDR;
                    pend_di = bus.DI;
                end
            end
            den_prev = bus.DEN;
            if (bus.DONE === 1'b1) done_cnt = done_cnt + 1;
        end
    end

    task automatic clear_log();
        log_we.delete();
        log_a.delete();
        log_di.delete();
        log_cyc.delete();
        exp_a.delete();
        exp_di.delete();
    endtask

    // Offer one entry and wait for the handshake; c_acc is the cycle in which the DUT acts on it.
    task automatic drive_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                               input bit last, input bit model, output int c_acc);
        bit acc;
        bit ok;
        if (model) begin
            exp_a.push_back(a);
            exp_di.push_back((exp_mem[a] & m) | (d & ~m));
            exp_mem[a] = (exp_mem[a] & m) | (d & ~m);
        end
        bus.CFG_VALID = 1'b1;
        bus.CFG_ADDR  = a;
        bus.CFG_MASK  = m;
        bus.CFG_DATA  = d;
        bus.CFG_LAST  = last;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            acc = bus.CFG_READY;
            @(negedge DCLK);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        c_acc = cyc;
        bus.CFG_VALID = 1'b0;
        chk("cfg_accepted", 32'(ok), 32'd1);
        chk("cfg_ready_after_accept", 32'(bus.CFG_READY), 32'd0);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_access_count"}, 32'(log_we.size()), 32'(2 * exp_a.size()));
        for (int i = 0; (i < exp_a.size()) && (2 * i + 1 < log_we.size()); i++) begin
            chk({tag, "_rd_we"}, 32'(log_we[2 * i]), 32'd0);
            chk({tag, "_rd_addr"}, 32'(log_a[2 * i]), 32'(exp_a[i]));
            chk({tag, "_wr_we"}, 32'(log_we[2 * i + 1]), 32'd1);
            chk({tag, "_wr_addr"}, 32'(log_a[2 * i + 1]), 32'(exp_a[i]));
            chk({tag, "_wr_di"}, 32'(log_di[2 * i + 1]), 32'(exp_di[i]));
        end
    endtask

    // Wait for PLL_RST release, check the access log, then either lock or let the lock wait expire.
    task automatic finish_seq(input bit lock_it);
        int r;
        int e;
        int d0;
        bit seen;
        seen = 1'b0;
        r = 0;
        for (int k = 0; k < 600; k++) begin
            if (bus.PLL_RST === 1'b0) begin
                seen = 1'b1;
                r = cyc;
                break;
            end
            @(negedge DCLK);
        end
        chk("release_seen", 32'(seen), 32'd1);
        check_log("seq");
        d0 = done_cnt;
        if (lock_it) begin
            repeat (3) @(negedge DCLK);
            bus.LOCKED = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge DCLK);
                if (bus.DONE === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("done_seen", 32'(seen), 32'd1);
            repeat (3) @(negedge DCLK);
            bus.LOCKED = 1'b0;
            chk("done_pulses", 32'(done_cnt - d0), 32'd1);
            chk("busy_after_done", 32'(bus.BUSY), 32'd0);
            chk("error_after_done", 32'(bus.ERROR), 32'd0);
        end else begin
            seen = 1'b0;
            e = 0;
            for (int k = 0; k < LOCK_TIMEOUT + 100; k++) begin
                if (bus.ERROR === 1'b1) begin
                    seen = 1'b1;
                    e = cyc;
                    break;
                end
                @(negedge DCLK);
            end
            chk("lock_error_seen", 32'(seen), 32'd1);
            chk("lock_timeout_cycles", 32'(e - r), 32'(LOCK_TIMEOUT));
            chk("lock_timeout_no_done", 32'(done_cnt - d0), 32'd0);
            chk("lock_timeout_busy", 32'(bus.BUSY), 32'd0);
        end
    endtask

    task automatic run_seq(input int n, input bit lock_it);
        int c;
        clear_log();
        for (int i = 0; i < n; i++) begin
            drive_entry(7'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), (i == n - 1), 1'b1, c);
            if (i != n - 1) repeat (2) @(negedge DCLK);
        end
        finish_seq(lock_it);
    endtask

    initial begin
        int c0;
        int cv;
        int e;
        int d0;
        bit seen;

        RST_N         = 1'b0;
        bus.CFG_VALID = 1'b0;
        bus.CFG_ADDR  = 7'd0;
        bus.CFG_MASK  = 16'd0;
        bus.CFG_DATA  = 16'd0;
        bus.CFG_LAST  = 1'b0;
        bus.LOCKED    = 1'b0;
        for (int i = 0; i < 128; i++) begin
            pll_mem[i] = 16'($urandom);
            exp_mem[i] = pll_mem[i];
        end
        repeat (3) @(negedge DCLK);
        chk("reset_outputs", {2'b00, bus.CFG_READY, bus.DEN, bus.DWE, bus.DADDR, bus.DI,
                              bus.PLL_RST, bus.BUSY, bus.DONE, bus.ERROR}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge DCLK);

        // Spurious DRDY while idle.
        spur_until = cyc + 2;
        repeat (3) @(negedge DCLK);
        chk("idle_spurious_busy", 32'(bus.BUSY), 32'd0);
        chk("idle_spurious_no_den", 32'(log_we.size()), 32'd0);

        // Single fixed entry with best-case DRDY; spurious DRDY across IDLE->HOLD.
        pll_mem[8] = 16'h5123;
        exp_mem[8] = 16'h5123;
        clear_log();
        cv = cyc;
        spur_until = cyc + 3;
        drive_entry(7'h08, 16'hF000, 16'h0ABC, 1'b1, 1'b1, c0);
        chk("hold_to_accept_latency", 32'(c0 - cv), 32'(RST_HOLD + 2));
        finish_seq(1'b1);
        if (log_we.size() >= 2) begin
            chk("t1_read_addr", 32'(log_a[0]), 32'h08);
            chk("t1_write_di", 32'(log_di[1]), 32'h5ABC);
            chk("t1_read_den_cycle", 32'(log_cyc[0]), 32'(c0));
            chk("t1_write_den_cycle", 32'(log_cyc[1]), 32'(c0 + 2));
        end
        chk("t1_pll_reg", 32'(pll_mem[8]), 32'h5ABC);

        // Randomised bursts with random DRDY latency.
        rand_dly = 1'b1;
        run_seq(3, 1'b1);
        run_seq(int'($urandom_range(1, 4)), 1'b1);
        run_seq(int'($urandom_range(2, 4)), 1'b1);

        // DRDY withheld on the second read.
        clear_log();
        d0 = done_cnt;
        drop_rd = rd_idx + 2;
        drive_entry(7'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0, 1'b1, c0);
        repeat (2) @(negedge DCLK);
        drive_entry(7'($urandom_range(8, 15)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, c0);
        seen = 1'b0;
        e = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.ERROR === 1'b1) begin
                seen = 1'b1;
                e = cyc;
                break;
            end
            @(negedge DCLK);
        end
        drop_rd = -1;
        chk("drp_error_seen", 32'(seen), 32'd1);
        chk("drp_timeout_accesses", 32'(log_we.size()), 32'd3);
        if (log_cyc.size() == 3) chk("drp_timeout_cycles", 32'(e - log_cyc[2]), 32'(DRDY_TIMEOUT));
        chk("drp_timeout_pll_rst", 32'(bus.PLL_RST), 32'd0);
        chk("drp_timeout_busy", 32'(bus.BUSY), 32'd0);
        chk("drp_timeout_no_done", 32'(done_cnt - d0), 32'd0);

        // LOCKED never arrives; then a new request clears ERROR.
        run_seq(1, 1'b0);
        bus.CFG_VALID = 1'b1;
        @(negedge DCLK);
        chk("error_cleared_on_start", 32'(bus.ERROR), 32'd0);
        chk("busy_on_start", 32'(bus.BUSY), 32'd1);
        run_seq(2, 1'b1);

        // Reset asserted while waiting for the write DRDY.
        rand_dly  = 1'b0;
        fixed_dly = 20;
        clear_log();
        drive_entry(7'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b1, 1'b0, c0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (log_we.size() >= 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge DCLK);
        end
        chk("reset_test_write_issued", 32'(seen), 32'd1);
        repeat (2) @(negedge DCLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_reset_outputs", {2'b00, bus.CFG_READY, bus.DEN, bus.DWE, bus.DADDR, bus.DI,
                                    bus.PLL_RST, bus.BUSY, bus.DONE, bus.ERROR}, 32'd0);
        @(negedge DCLK);
        fixed_dly = 1;
        repeat (2) @(negedge DCLK);
        RST_N = 1'b1;
        repeat (2) @(negedge DCLK);
        chk("after_reset_idle", 32'(bus.BUSY), 32'd0);
        rand_dly = 1'b1;
        run_seq(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
